// File: rtl/ccr_pkg.sv
// ccr_pkg: constants shared by the condition-code stage, the ALU and the decoder.
//   - ALU one-hot op bit indices
//   - branch condition encodings
//   - CCR bit positions (Z/N/C)
//   - update masks per op class
//   - small helper to detect an exactly-one-hot op vector
package ccr_pkg;

  localparam int CCR_BITS = 3;
  localparam int OP_BITS  = 7;

  // One-hot ALU op bit indices
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_NOT = 4;
  localparam int OP_SHR = 5;
  localparam int OP_SHL = 6;

  // Ops that produce a carry/borrow and therefore rewrite all three flags
  localparam logic [OP_BITS-1:0] ARITH_OPS = 7'b110_0011;

  // CCR bit positions
  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int C_BIT = 2;

  // Flag update masks per op class
  localparam logic [CCR_BITS-1:0] MASK_ARITH = 3'b111;
  localparam logic [CCR_BITS-1:0] MASK_LOGIC = 3'b011;

  // Branch condition encodings; JZ/JN/JC values equal the tested CCR bit index
  typedef enum logic [1:0] {
    BR_JZ  = 2'b00,
    BR_JN  = 2'b01,
    BR_JC  = 2'b10,
    BR_JMP = 2'b11
  } br_cond_t;

  function automatic logic is_onehot(input logic [OP_BITS-1:0] v);
    return (v != '0) && ((v & (v - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/ccr_cond_eval.sv
// ccr_cond_eval: pure combinational branch resolver.
//   ccr      in  3  registered flags
//   br_valid in  1  conditional branch present in the resolve slot
//   br_cond  in  2  JZ/JN/JC/JMP
//   br_taken out 1  branch resolves taken
//   clr_mask out 3  flag to clear because a conditional branch consumed it
module ccr_cond_eval
  import ccr_pkg::*;
(
  input  logic [CCR_BITS-1:0] ccr,
  input  logic                br_valid,
  input  logic [1:0]          br_cond,
  output logic                br_taken,
  output logic [CCR_BITS-1:0] clr_mask
);

  always_comb begin
    br_taken = 1'b0;
    clr_mask = '0;
    if (br_valid) begin
      case (br_cond)
        BR_JZ: begin
          br_taken        = ccr[Z_BIT];
          clr_mask[Z_BIT] = ccr[Z_BIT];
        end
        BR_JN: begin
          br_taken        = ccr[N_BIT];
          clr_mask[N_BIT] = ccr[N_BIT];
        end
        BR_JC: begin
          br_taken        = ccr[C_BIT];
          clr_mask[C_BIT] = ccr[C_BIT];
        end
        default: br_taken = 1'b1;  // JMP: unconditional, tests no flag
      endcase
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage behind the 16-bit ALU.
//   clk, rst                      clock, async active-high reset
//   alu_en, alu_op                ALU result valid / one-hot op
//   zero_in, neg_in, carry_in     ALU flags
//   setc, clrc                    explicit carry set / clear
//   br_valid, br_cond             branch in the resolve slot
//   int_save, rti_restore         single-level CCR save / restore
//   ccr                           registered flags {C,N,Z}
//   br_taken                      combinational branch outcome
//   shadow_valid                  shadow holds a saved CCR
//   restore_err                   one-cycle pulse: RTI with empty shadow
// Next-state priority: rti restore > setc/clrc > ALU update > branch clear > hold.
module ccr_unit
  import ccr_pkg::*;
#(
  parameter int CCR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_en,
  input  logic [OP_BITS-1:0] alu_op,
  input  logic               zero_in,
  input  logic               neg_in,
  input  logic               carry_in,
  input  logic               setc,
  input  logic               clrc,
  input  logic               br_valid,
  input  logic [1:0]         br_cond,
  input  logic               int_save,
  input  logic               rti_restore,
  output logic [CCR_W-1:0]   ccr,
  output logic               br_taken,
  output logic               shadow_valid,
  output logic               restore_err
);

  logic [CCR_W-1:0] shadow;
  logic [CCR_W-1:0] ccr_nxt;
  logic [CCR_W-1:0] clr_mask;
  logic [CCR_W-1:0] upd_mask;
  logic [CCR_W-1:0] alu_flags;
  logic             alu_hit;
  logic             restore_ok;

  ccr_cond_eval u_cond (
    .ccr      (ccr),
    .br_valid (br_valid),
    .br_cond  (br_cond),
    .br_taken (br_taken),
    .clr_mask (clr_mask)
  );

  assign restore_ok = rti_restore && shadow_valid;

  always_comb begin
    alu_flags        = '0;
    alu_flags[Z_BIT] = zero_in;
    alu_flags[N_BIT] = neg_in;
    alu_flags[C_BIT] = carry_in;

    // Zero or multi-hot ops are treated as a bubble: no flag change.
    alu_hit  = alu_en && is_onehot(alu_op);
    upd_mask = '0;
    if (alu_hit) upd_mask = ((alu_op & ARITH_OPS) != '0) ? MASK_ARITH : MASK_LOGIC;

    // Apply lowest priority first so later writes override earlier ones.
    ccr_nxt = ccr & ~clr_mask;
    ccr_nxt = (ccr_nxt & ~upd_mask) | (alu_flags & upd_mask);
    if (setc && !clrc)      ccr_nxt[C_BIT] = 1'b1;
    else if (clrc && !setc) ccr_nxt[C_BIT] = 1'b0;
    if (restore_ok)         ccr_nxt = shadow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr          <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      restore_err  <= 1'b0;
    end else begin
      ccr         <= ccr_nxt;
      restore_err <= rti_restore && !shadow_valid;
      // A save in the same cycle as a restore captures the pre-restore ccr
      // and keeps the shadow occupied.
      if (int_save) begin
        shadow       <= ccr;
        shadow_valid <= 1'b1;
      end else if (restore_ok) begin
        shadow_valid <= 1'b0;
      end
    end
  end

endmodule
